// File: rtl/dp_pkg.sv
// dp_pkg: shared definitions for the datapath control sequencer.
//   - opcode / funct field constants for the supported instruction subset
//   - ALUControl encodings
//   - sequencer state enum
//   - ctrl_t: the registered mux-select / ALU bundle produced by dp_decode
package dp_pkg;

  // Opcode field inst[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Funct field inst[5:0], meaningful only for R-type
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_e;

  // Per-instruction control, captured at accept and held until retire/abort.
  typedef struct packed {
    logic    reg_dst;     // 1 = write rd
    logic    alu_src;     // 1 = sign-extended immediate on ALU B
    logic    mem_to_reg;  // 1 = writeback from memory data
    logic    is_load;
    logic    is_store;
    alu_op_e alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '{
    reg_dst:    1'b0,
    alu_src:    1'b0,
    mem_to_reg: 1'b0,
    is_load:    1'b0,
    is_store:   1'b0,
    alu_op:     ALU_AND
  };

endpackage

// File: rtl/dp_if.sv
// dp_if: instruction handshake, memory-ready and datapath control bundle
// between an instruction source / datapath (master) and dp_sequencer (slave).
//   inst_valid/inst/inst_ready : one-at-a-time instruction handshake
//   mem_ready                  : data memory finished current access
//   RegDst..ALUControl, Inst   : datapath controls and latched inst[25:0]
//   done/illegal               : one-cycle retire / abort pulses
//   retired                    : retired-instruction count (CNT_W bits)
interface dp_if #(
  parameter int CNT_W = 32
);
  logic             inst_valid;
  logic [31:0]      inst;
  logic             inst_ready;
  logic             mem_ready;
  logic             RegDst;
  logic             RegWrite;
  logic             ALUSrc;
  logic             MemWrite;
  logic             MemRead;
  logic             MemToReg;
  logic [2:0]       ALUControl;
  logic [25:0]      Inst;
  logic             done;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    output inst_valid, inst, mem_ready,
    input  inst_ready, RegDst, RegWrite, ALUSrc, MemWrite, MemRead,
           MemToReg, ALUControl, Inst, done, illegal, retired
  );

  modport slave (
    input  inst_valid, inst, mem_ready,
    output inst_ready, RegDst, RegWrite, ALUSrc, MemWrite, MemRead,
           MemToReg, ALUControl, Inst, done, illegal, retired
  );
endinterface

// File: rtl/dp_decode.sv
// dp_decode: purely combinational instruction classifier.
//   op    in  6   inst[31:26]
//   funct in  6   inst[5:0]
//   ctrl  out     control bundle (CTRL_NONE for unsupported encodings)
//   legal out 1   encoding is in the supported subset
module dp_decode
  import dp_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ctrl_t      ctrl,
  output logic       legal
);

  // NOTE: every output of a combinational block gets a default before the
  // case so that no path leaves it unassigned; otherwise a latch is inferred.
  always_comb begin
    ctrl  = CTRL_NONE;
    legal = 1'b0;
    case (op)
      OP_RTYPE: begin
        ctrl.reg_dst = 1'b1;
        legal        = 1'b1;
        case (funct)
          FN_ADD:  ctrl.alu_op = ALU_ADD;
          FN_SUB:  ctrl.alu_op = ALU_SUB;
          FN_AND:  ctrl.alu_op = ALU_AND;
          FN_OR:   ctrl.alu_op = ALU_OR;
          FN_SLT:  ctrl.alu_op = ALU_SLT;
          default: begin
            // Unknown funct: return a clean all-zero bundle, not a half-built one.
            ctrl  = CTRL_NONE;
            legal = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        ctrl.alu_src = 1'b1;
        ctrl.alu_op  = ALU_ADD;
        legal        = 1'b1;
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.is_load    = 1'b1;
        ctrl.alu_op     = ALU_ADD;
        legal           = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src  = 1'b1;
        ctrl.is_store = 1'b1;
        ctrl.alu_op   = ALU_ADD;
        legal         = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dp_sequencer.sv
// dp_sequencer: multi-cycle control sequencer for the regfile/ALU/SRAM
// datapath. Accepts one instruction at a time and walks it through
// DECODE -> EXEC -> [MEM] -> [WB], driving the datapath controls.
//   clk    in  clock, all state updates on the rising edge
//   reset  in  synchronous active-high reset
//   bus    dp_if.slave: handshake, mem_ready, controls, done/illegal, retired
// Parameters:
//   CNT_W       width of the retired-instruction counter (wraps)
//   MEM_TIMEOUT MEM-phase cycles without mem_ready before abort (0 = never)
module dp_sequencer
  import dp_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input logic clk,
  input logic reset,
  dp_if.slave bus
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e           state_q, state_d;
  ctrl_t            ctrl_q;
  ctrl_t            dec_ctrl;
  logic             dec_legal;
  logic             legal_q;
  logic [25:0]      inst_q;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0] retired_q;

  logic accept;
  logic reg_write;
  logic mem_read;
  logic mem_write;
  logic done;
  logic illegal;

  // Decode straight off the offered word so the mux selects are already
  // valid in the DECODE cycle that follows the accept.
  dp_decode u_decode (
    .op    (bus.inst[31:26]),
    .funct (bus.inst[5:0]),
    .ctrl  (dec_ctrl),
    .legal (dec_legal)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // inst_ready is high exactly in IDLE, so valid alone completes it.
        if (bus.inst_valid) begin
          accept  = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!legal_q) begin
          illegal = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = (ctrl_q.is_load || ctrl_q.is_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_read  = ctrl_q.is_load;
        mem_write = ctrl_q.is_store;
        if (bus.mem_ready) begin
          if (ctrl_q.is_store) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WB;
          end
        end else if ((MEM_TIMEOUT > 0) && (wait_q == WAIT_LAST)) begin
          // Last permitted wait cycle: abort; strobes fall with the IDLE entry.
          illegal = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        done      = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q    <= CTRL_NONE;
      legal_q   <= 1'b0;
      inst_q    <= '0;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      if (accept) begin
        inst_q  <= bus.inst[25:0];
        ctrl_q  <= dec_ctrl;
        legal_q <= dec_legal;
      end else if (state_d == S_IDLE) begin
        // Selects read as zero whenever the sequencer is idle.
        ctrl_q  <= CTRL_NONE;
        legal_q <= 1'b0;
      end

      // Counts MEM cycles already spent waiting; restarts on every MEM entry.
      if (state_q == S_MEM) wait_q <= wait_q + WAIT_W'(1);
      else                  wait_q <= '0;

      if (done) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign bus.inst_ready = (state_q == S_IDLE);
  assign bus.RegDst     = ctrl_q.reg_dst;
  assign bus.ALUSrc     = ctrl_q.alu_src;
  assign bus.MemToReg   = ctrl_q.mem_to_reg;
  assign bus.ALUControl = ctrl_q.alu_op;
  assign bus.RegWrite   = reg_write;
  assign bus.MemRead    = mem_read;
  assign bus.MemWrite   = mem_write;
  assign bus.Inst       = inst_q;
  assign bus.done       = done;
  assign bus.illegal    = illegal;
  assign bus.retired    = retired_q;

endmodule

// File: doc/dp_sequencer.md
Name: dp_sequencer

Overview:
Multi-cycle control sequencer for the register-file/ALU/SRAM datapath. Accepts one 32-bit instruction at a time over a valid/ready handshake and decodes it. Drives RegDst, RegWrite, ALUSrc, MemWrite, MemToReg, MemRead, ALUControl and the 26-bit Inst field through fixed DECODE/EXEC/MEM/WB phases. Keeps write strobes clean, waits on a memory-ready signal, and flags illegal opcodes.

Parameters:
CNT_W, 32, width of the retired-instruction counter
MEM_TIMEOUT, 15, max MEM-phase cycles waiting on mem_ready before error abort (0 = no timeout)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
inst_valid  in  1  instruction offered
inst  in  32  instruction word (op=[31:26], funct=[5:0])
inst_ready  out  1  sequencer can accept (high only in IDLE)
mem_ready  in  1  data memory completed current access (tie 1 for single-cycle SRAM)
RegDst  out  1  write-register select (1 = rd)
RegWrite  out  1  register-file write strobe
ALUSrc  out  1  ALU B select (1 = sign-extended imm)
MemWrite  out  1  SRAM write enable
MemRead  out  1  SRAM read enable
MemToReg  out  1  writeback select (1 = memory data)
ALUControl  out  3  ALU op
Inst  out  26  latched inst[25:0] to datapath
done  out  1  one-cycle pulse on instruction retire
illegal  out  1  one-cycle pulse on unsupported op/funct or MEM timeout
retired  out  CNT_W  count of retired instructions

Behaviour:
- Reset: state=IDLE. All control outputs, done and illegal are 0. Inst=0, retired=0. inst_ready=1 from the first post-reset cycle. Reset mid-instruction aborts it with no strobes, no retire.
- States: IDLE, DECODE, EXEC, MEM, WB.
- IDLE: if inst_valid&&inst_ready, latch inst (Inst<=inst[25:0]), go DECODE. Otherwise stay in IDLE.
- DECODE: classify. R-type (op 000000): funct 100000 add->010, 100010 sub->110, 100100 and->000, 100101 or->001, 101010 slt->111; RegDst=1, ALUSrc=0. addi (001000): ALU 010, RegDst=0, ALUSrc=1. lw (100011) / sw (101011): ALU 010, ALUSrc=1, RegDst=0, MemToReg=1 for lw. Any other op/funct: pulse illegal, go IDLE, no retire. Otherwise go EXEC.
- Mux selects and ALUControl are registered in DECODE and held stable through the final state of the instruction. They are 0 in IDLE.
- EXEC: one cycle, no strobes. lw/sw -> MEM; R-type/addi -> WB.
- MEM: MemRead=1 (lw) or MemWrite=1 (sw), held while in MEM.
  - Exit on mem_ready=1 in that cycle: lw -> WB; sw -> retire, IDLE.
  - If MEM_TIMEOUT>0 and MEM_TIMEOUT cycles pass without mem_ready: drop strobes, pulse illegal, go IDLE, no retire.
- WB: RegWrite=1 for exactly one cycle, retire, go IDLE.
- Retire: done=1 for one cycle (the WB cycle, or the sw MEM-exit cycle); retired+=1, wrapping at 2^CNT_W.
- RegWrite and MemWrite are never high in the same cycle. Neither is ever high outside WB/MEM respectively.
- Latency from accept to done: R/addi = 3 cycles. lw = 4 + extra MEM wait cycles. sw = 3 + extra MEM wait cycles. Next accept is possible the cycle after done.
- inst_valid while busy: ignored (inst_ready=0). The offer must be held by the source.

Decomposition:
- Shared package dp_pkg: opcode/funct constants, ALUControl encodings (ALU_ADD=010, ALU_SUB=110, ALU_AND=000, ALU_OR=001, ALU_SLT=111), state enum.
- Sub-module dp_decode: combinational op/funct -> {ctrl bundle, legal}. FSM and counter live in dp_sequencer.

Test Plan:
- add r3,r1,r2 (0x00221820) offered after reset, mem_ready=1 -> accept cycle 0. RegDst=1/ALUSrc=0/ALUControl=010 from cycle 1. RegWrite high only at cycle 3, done at cycle 3, retired=1, inst_ready back high at cycle 4.
- lw r2,4(r1) (0x8C220004), mem_ready low 2 cycles then high -> MemRead high 3 cycles. RegWrite+MemToReg=1 in the following WB cycle, done at accept+6.
- sw r2,8(r1) (0xAC220008), mem_ready=1 -> MemWrite exactly 1 cycle at accept+3, done same cycle, RegWrite never high.
- Illegal op 0xFC000000 -> illegal pulse at accept+1, no strobes, retired unchanged, IDLE next cycle. R-type funct 000111 -> same behaviour.
- lw with mem_ready stuck 0, MEM_TIMEOUT=15 -> MemRead 15 cycles then drops; illegal pulse, no RegWrite, returns to IDLE.
- reset asserted during MEM of sw -> next cycle all strobes 0, retired=0, inst_ready=1. Back-to-back addi stream with inst_valid constant -> one retire every 4 cycles.
